// File: rtl/ir_cmd_dispatcher.sv
// ir_cmd_dispatcher: turns debounced key presses into a queued
// valid/ready stream of IR command words, with NEC auto-repeat.
// Ports:
//   clk, rst          clock, async active-high reset
//   key_pressed       one-cycle press pulses, one bit per key
//   key_state         debounced key levels, 1 = held
//   cmd_ready         encoder accepts the current command
//   cmd_valid         cmd_data/cmd_repeat are valid
//   cmd_data          command word from CMD_TABLE
//   cmd_repeat        1 = repeat frame of the last command
//   fifo_level        queued key indices (0..FIFO_DEPTH)
//   drop_cnt          saturating count of merged presses
module ir_cmd_dispatcher #(
   parameter int NUM_KEYS = 4,
   parameter int CMD_W = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [NUM_KEYS*CMD_W-1:0] CMD_TABLE = {
      32'h9A650707, 32'h9E610707, 32'h9F600707, 32'h9D620707},
   parameter bit REPEAT_EN = 1'b1,
   parameter int REPEAT_CYCLES = 2700000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_KEYS-1:0]                key_pressed,
   input  logic [NUM_KEYS-1:0]                key_state,
   input  logic                               cmd_ready,
   output logic                               cmd_valid,
   output logic [CMD_W-1:0]                   cmd_data,
   output logic                               cmd_repeat,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic [7:0]                         drop_cnt
);

   localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   function automatic logic [CMD_W-1:0] cmd_of(
      input logic [IDX_W-1:0] k);
      return CMD_TABLE[int'(k)*CMD_W +: CMD_W];
   endfunction

   logic [NUM_KEYS-1:0] pend_q, pend_d, clr;
   logic [IDX_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [7:0]          drop_q, drop_d;
   logic [8:0]          ndrop, dsum;
   logic                valid_q, valid_d;
   logic [CMD_W-1:0]    data_q, data_d;
   logic                rep_q, rep_d;
   logic [IDX_W-1:0]    skey_q, skey_d;
   logic [IDX_W-1:0]    arb_idx;
   logic                empty, full, load, accept;
   logic                push, pop, due, due_go;
   logic [CMD_W-1:0]    rep_cmd;

   assign empty  = (level_q == '0);
   assign full   = (level_q == LVL_W'(FIFO_DEPTH));
   assign load   = !valid_q || cmd_ready;
   assign accept = valid_q && cmd_ready;
   assign pop    = load && !empty;
   // A pop frees a slot in the same cycle, so push may proceed when full.
   assign push   = (|pend_q) && (!full || pop);
   assign due_go = due && (pend_q == '0);

   // Lowest set pend bit wins.
   always_comb begin
      arb_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pend_q[i]) arb_idx = IDX_W'(i);
      end
   end

   always_comb begin
      clr = '0;
      if (push) clr[arb_idx] = 1'b1;
      pend_d = (pend_q & ~clr) | key_pressed;
      ndrop = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (key_pressed[i] && pend_q[i] && !clr[i]) ndrop = ndrop + 9'd1;
      end
      dsum = {1'b0, drop_q} + ndrop;
      drop_d = dsum[8] ? 8'hFF : dsum[7:0];
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
   end

   // Output slot: normal frames first, repeats only when idle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      rep_d   = rep_q;
      skey_d  = skey_q;
      if (load) begin
         if (!empty) begin
            valid_d = 1'b1;
            data_d  = cmd_of(mem_q[rd_ptr_q]);
            rep_d   = 1'b0;
            skey_d  = mem_q[rd_ptr_q];
         end else if (due_go) begin
            valid_d = 1'b1;
            data_d  = rep_cmd;
            rep_d   = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   if (REPEAT_EN) begin : g_rep
      localparam int TW = $clog2(REPEAT_CYCLES);
      localparam logic [TW-1:0] DUE_V = TW'(REPEAT_CYCLES - 1);
      logic [TW-1:0]    tmr_q, tmr_d;
      logic [IDX_W-1:0] lkey_q, lkey_d;
      logic             lvld_q, lvld_d;

      always_comb begin
         tmr_d  = tmr_q;
         lkey_d = lkey_q;
         lvld_d = lvld_q;
         if (lvld_q && !key_state[lkey_q]) begin
            lvld_d = 1'b0;
            tmr_d  = '0;
         end else if (lvld_q && tmr_q != DUE_V) begin
            tmr_d = tmr_q + 1'b1;
         end
         if (accept) begin
            tmr_d = '0;
            if (!rep_q) begin
               lkey_d = skey_q;
               lvld_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            tmr_q  <= '0;
            lkey_q <= '0;
            lvld_q <= 1'b0;
         end else begin
            tmr_q  <= tmr_d;
            lkey_q <= lkey_d;
            lvld_q <= lvld_d;
         end
      end

      // Any acceptance this cycle restarts the period, so no back-to-back repeat.
      assign due     = lvld_q && (tmr_q == DUE_V) && !accept;
      assign rep_cmd = cmd_of(lkey_q);
   end else begin : g_norep
      assign due     = 1'b0;
      assign rep_cmd = '0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= arb_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         rep_q    <= 1'b0;
         skey_q   <= '0;
      end else begin
         pend_q   <= pend_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         rep_q    <= rep_d;
         skey_q   <= skey_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign cmd_valid  = valid_q;
   assign cmd_data   = data_q;
   assign cmd_repeat = rep_q;
   assign fifo_level = level_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
// tb_ir_cmd_dispatcher: table-driven and directed checks for
// ir_cmd_dispatcher with a short repeat period.
module tb_ir_cmd_dispatcher;

   localparam logic [31:0] D0 = 32'h9D620707;
   localparam logic [31:0] D1 = 32'h9F600707;
   localparam logic [31:0] D2 = 32'h9E610707;
   localparam logic [31:0] D3 = 32'h9A650707;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  kp, ks;
   logic        rdy;
   logic        vld;
   logic [31:0] dat;
   logic        rep;
   logic [2:0]  lvl;
   logic [7:0]  drp;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic        rdy;
      logic [3:0]  kp;
      logic        ev;
      logic [31:0] ed;
      logic [2:0]  el;
      logic [7:0]  edr;
   } vec_t;

   vec_t vec [40];
   int   nv = 0;

   int          vc [$];
   logic [31:0] vd [$];
   logic        vr [$];

   always #5 clk = ~clk;

   ir_cmd_dispatcher #(
      .NUM_KEYS(4),
      .CMD_W(32),
      .FIFO_DEPTH(4),
      .REPEAT_EN(1'b1),
      .REPEAT_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_pressed(kp),
      .key_state(ks),
      .cmd_ready(rdy),
      .cmd_valid(vld),
      .cmd_data(dat),
      .cmd_repeat(rep),
      .fifo_level(lvl),
      .drop_cnt(drp)
   );

   task automatic add(input logic r, input logic [3:0] k, input logic v,
                      input logic [31:0] d, input logic [2:0] l,
                      input logic [7:0] dr);
      vec[nv] = '{r, k, v, d, l, dr};
      nv++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      kp  = '0;
      ks  = '0;
      rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_log();
      vc.delete();
      vd.delete();
      vr.delete();
   endtask

   task automatic log_frame(input int c);
      if (vld) begin
         vc.push_back(c);
         vd.push_back(dat);
         vr.push_back(rep);
      end
   endtask

   initial begin
      // Row i: outputs expected at negedge i, then inputs driven.
      // Single press of key 0.
      add(1, 4'b0001, 0, 0,  0, 0);
      add(1, 4'b0000, 0, 0,  0, 0);
      add(1, 4'b0000, 0, 0,  1, 0);
      add(1, 4'b0000, 1, D0, 0, 0);
      add(1, 4'b0000, 0, D0, 0, 0);
      // All four keys at once.
      add(1, 4'b1111, 0, D0, 0, 0);
      add(1, 4'b0000, 0, D0, 0, 0);
      add(1, 4'b0000, 0, D0, 1, 0);
      add(1, 4'b0000, 1, D0, 1, 0);
      add(1, 4'b0000, 1, D1, 1, 0);
      add(1, 4'b0000, 1, D2, 1, 0);
      add(1, 4'b0000, 1, D3, 0, 0);
      // Backpressure: slot holds key0, FIFO fills, then a drop.
      add(0, 4'b0001, 0, D3, 0, 0);
      add(0, 4'b0000, 0, D3, 0, 0);
      add(0, 4'b0000, 0, D3, 1, 0);
      add(0, 4'b0010, 1, D0, 0, 0);
      add(0, 4'b0000, 1, D0, 0, 0);
      add(0, 4'b0000, 1, D0, 1, 0);
      add(0, 4'b0100, 1, D0, 1, 0);
      add(0, 4'b0000, 1, D0, 1, 0);
      add(0, 4'b0000, 1, D0, 2, 0);
      add(0, 4'b1000, 1, D0, 2, 0);
      add(0, 4'b0000, 1, D0, 2, 0);
      add(0, 4'b0000, 1, D0, 3, 0);
      add(0, 4'b0001, 1, D0, 3, 0);
      add(0, 4'b0000, 1, D0, 3, 0);
      add(0, 4'b0000, 1, D0, 4, 0);
      add(0, 4'b0001, 1, D0, 4, 0);
      add(0, 4'b0000, 1, D0, 4, 0);
      add(0, 4'b0000, 1, D0, 4, 0);
      add(0, 4'b0001, 1, D0, 4, 0);
      add(1, 4'b0000, 1, D0, 4, 1);
      add(1, 4'b0000, 1, D1, 4, 1);
      add(1, 4'b0000, 1, D2, 3, 1);
      add(1, 4'b0000, 1, D3, 2, 1);
      add(1, 4'b0000, 1, D0, 1, 1);
      add(1, 4'b0000, 1, D0, 0, 1);
      add(1, 4'b0000, 0, D0, 0, 1);

      do_reset();
      chk("reset rep", 32'(rep), 32'(1'b0));
      for (int i = 0; i < nv; i++) begin
         chk($sformatf("row%0d valid", i), 32'(vld), 32'(vec[i].ev));
         chk($sformatf("row%0d data", i), dat, vec[i].ed);
         chk($sformatf("row%0d level", i), 32'(lvl), 32'(vec[i].el));
         chk($sformatf("row%0d drop", i), 32'(drp), 32'(vec[i].edr));
         if (vec[i].ev) chk($sformatf("row%0d rep", i), 32'(rep), 32'(1'b0));
         rdy = vec[i].rdy;
         kp  = vec[i].kp;
         ks  = '0;
         @(negedge clk);
      end

      // Reset while a frame is stalled and two entries are queued.
      rdy = 1'b0;
      kp  = 4'b0001;
      @(negedge clk);
      kp = '0;
      @(negedge clk);
      @(negedge clk);
      kp = 4'b0110;
      @(negedge clk);
      kp = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("pre-rst valid", 32'(vld), 32'(1'b1));
      chk("pre-rst level", 32'(lvl), 32'd2);
      chk("pre-rst drop", 32'(drp), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", 32'(vld), 32'(1'b0));
      chk("async rst level", 32'(lvl), 32'd0);
      chk("async rst drop", 32'(drp), 32'd0);
      chk("async rst data", dat, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rdy = 1'b1;
      clear_log();
      for (int c = 0; c < 20; c++) begin
         log_frame(c);
         @(negedge clk);
      end
      chk("post-rst frames", 32'(vc.size()), 32'd0);

      // Hold key 2 for 350 cycles: normal frame, then repeats.
      do_reset();
      clear_log();
      for (int c = 0; c <= 420; c++) begin
         log_frame(c);
         rdy = 1'b1;
         kp  = (c == 0) ? 4'b0100 : 4'b0000;
         ks  = (c < 350) ? 4'b0100 : 4'b0000;
         @(negedge clk);
      end
      begin
         int ec [4] = '{3, 104, 205, 306};
         chk("rpt count", 32'(vc.size()), 32'd4);
         for (int i = 0; i < 4 && i < vc.size(); i++) begin
            chk($sformatf("rpt%0d cycle", i), 32'(vc[i]), 32'(ec[i]));
            chk($sformatf("rpt%0d data", i), vd[i], D2);
            chk($sformatf("rpt%0d flag", i), 32'(vr[i]), 32'(i > 0));
         end
      end

      // Key 1 held; key 3 pressed as key 1's repeat becomes due.
      do_reset();
      clear_log();
      for (int c = 0; c <= 250; c++) begin
         log_frame(c);
         rdy = 1'b1;
         kp  = (c == 0) ? 4'b0010 : (c == 102) ? 4'b1000 : 4'b0000;
         ks  = (c == 102) ? 4'b1010 : 4'b0010;
         @(negedge clk);
      end
      chk("nbr count", 32'(vc.size()), 32'd2);
      if (vc.size() >= 2) begin
         chk("nbr f0 cycle", 32'(vc[0]), 32'd3);
         chk("nbr f0 data", vd[0], D1);
         chk("nbr f0 flag", 32'(vr[0]), 32'd0);
         chk("nbr f1 cycle", 32'(vc[1]), 32'd105);
         chk("nbr f1 data", vd[1], D3);
         chk("nbr f1 flag", 32'(vr[1]), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
